uart_tx_fifo: RTL and testbench

Byte-oriented UART transmitter for the user project, driving the serial line routed to mprj_io[6] that the testbench UART monitor listens on. Firmware or core logic pushes bytes through a valid/ready interface into a small FIFO. The block serialises each byte as 8N1, LSB first, at a fixed clocks-per-bit rate. It lets the core report progress as text, alongside the mprj_io status nibbles.

---
 rtl/uart_pkg.sv | 8 +
 rtl/uart_tx_fifo_sync_fifo.sv | 53 +++++
 rtl/uart_tx_fifo.sv | 128 ++++++++++++
 tb/tb_uart_tx_fifo.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame geometry and default bit rate.
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;

  localparam int UART_DATA_BITS    = 8;
  localparam int UART_FRAME_BITS   = 10;
  localparam int UART_CLKS_PER_BIT = 4167;
endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Single-clock FIFO with an explicit occupancy count, so full and empty never alias.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small byte FIFO; frames run back-to-back while data is queued.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic [7:0]                    data_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  output logic                          tx_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);
  localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        LAST_BIT = 3'(UART_DATA_BITS - 1);

  uart_state_e      r_state;
  logic [CNT_W-1:0] r_baud;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_tx;

  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_bit_done;
  logic [7:0]       w_head;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (wb_clk_i),
    .i_rst   (wb_rst_i),
    .i_push  (valid_i),
    .i_data  (data_i),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (fifo_count_o)
  );

  assign w_bit_done = (r_baud == LAST_CNT);
  assign ready_o    = !w_full;
  assign busy_o     = (r_state != IDLE) || !w_empty;
  assign tx_o       = r_tx;

  // The head is popped either from idle or at the end of a stop bit, giving gapless frames.
  always_comb begin
    w_pop = 1'b0;
    case (r_state)
      IDLE:    w_pop = !w_empty;
      STOP:    w_pop = w_bit_done && !w_empty;
      default: w_pop = 1'b0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state   <= IDLE;
      r_tx      <= 1'b1;
      r_baud    <= '0;
      r_bit_idx <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_shift   <= w_head;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_tx      <= 1'b0;
            r_state   <= START;
          end
        end
        START: begin
          if (w_bit_done) begin
            r_baud  <= '0;
            r_tx    <= r_shift[0];
            r_state <= DATA;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        DATA: begin
          if (w_bit_done) begin
            r_baud <= '0;
            if (r_bit_idx == LAST_BIT) begin
              r_tx    <= 1'b1;
              r_state <= STOP;
            end else begin
              r_shift   <= r_shift >> 1;
              r_bit_idx <= r_bit_idx + 1'b1;
              r_tx      <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        STOP: begin
          if (w_bit_done) begin
            r_baud <= '0;
            if (w_pop) begin
              r_shift   <= w_head;
              r_bit_idx <= '0;
              r_tx      <= 1'b0;
              r_state   <= START;
            end else begin
              r_tx    <= 1'b1;
              r_state <= IDLE;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: two configurations, serial monitors feeding a byte scoreboard.
module tb_uart_tx_fifo;
  localparam int CPB_A = 4;
  localparam int CPB_B = 2;

  logic       clk;
  logic       rst;
  logic [7:0] data_a, data_b;
  logic       valid_a, valid_b;
  logic       ready_a, ready_b;
  logic       tx_a, tx_b;
  logic       busy_a, busy_b;
  logic [2:0] count_a;
  logic [1:0] count_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int         st0[$];
  int         st1[$];

  logic       m_act  [2];
  int         m_t    [2];
  logic [7:0] m_byte [2];

  uart_tx_fifo #(.CLKS_PER_BIT(CPB_A), .FIFO_DEPTH(4)) u_dut_a (
    .wb_clk_i(clk), .wb_rst_i(rst), .data_i(data_a), .valid_i(valid_a),
    .ready_o(ready_a), .tx_o(tx_a), .busy_o(busy_a), .fifo_count_o(count_a)
  );

  uart_tx_fifo #(.CLKS_PER_BIT(CPB_B), .FIFO_DEPTH(2)) u_dut_b (
    .wb_clk_i(clk), .wb_rst_i(rst), .data_i(data_b), .valid_i(valid_b),
    .ready_o(ready_b), .tx_o(tx_b), .busy_o(busy_b), .fifo_count_o(count_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic fail(input string tag);
    errors++;
    $error("FAIL %s at cycle %0d", tag, cyc);
  endtask

  // Serial receivers: sample the centre of each bit, abandon a frame on reset.
  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      int         cpb;
      int         k;
      logic       line;
      logic [7:0] exp_b;
      cpb  = (i == 0) ? CPB_A : CPB_B;
      line = (i == 0) ? tx_a : tx_b;
      if (rst) begin
        m_act[i] = 1'b0;
      end else if (!m_act[i]) begin
        if (line === 1'b0) begin
          m_act[i] = 1'b1;
          m_t[i]   = 0;
          if (i == 0) st0.push_back(cyc); else st1.push_back(cyc);
        end
      end else begin
        m_t[i]++;
        if ((m_t[i] % cpb) == (cpb / 2)) begin
          k = m_t[i] / cpb;
          if (k == 0) begin
            checks++; if (line !== 1'b0) fail("rx_start_low");
          end else if (k <= 8) begin
            m_byte[i][k-1] = line;
          end else begin
            checks++; if (line !== 1'b1) fail("rx_stop_high");
            m_act[i] = 1'b0;
            if (i == 0) begin
              checks++; if (q0.size() == 0) fail("rx0_expected");
              if (q0.size() > 0) begin
                exp_b = q0.pop_front();
                checks++; if (m_byte[i] !== exp_b) fail("rx0_byte");
              end
            end else begin
              checks++; if (q1.size() == 0) fail("rx1_expected");
              if (q1.size() > 0) begin
                exp_b = q1.pop_front();
                checks++; if (m_byte[i] !== exp_b) fail("rx1_byte");
              end
            end
          end
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [7:0] b, input bit exp_rx);
    int n;
    n = 0;
    data_a  = b;
    valid_a = 1'b1;
    while (ready_a !== 1'b1 && n < 200) begin tick; n++; end
    checks++; if (n >= 200) fail("push_a_wait");
    if (exp_rx) q0.push_back(b);
    tick;
    valid_a = 1'b0;
  endtask

  task automatic push_b(input logic [7:0] b);
    int n;
    n = 0;
    data_b  = b;
    valid_b = 1'b1;
    while (ready_b !== 1'b1 && n < 200) begin tick; n++; end
    checks++; if (n >= 200) fail("push_b_wait");
    q1.push_back(b);
    tick;
    valid_b = 1'b0;
  endtask

  task automatic drain;
    int n;
    n = 0;
    while ((busy_a || busy_b || q0.size() != 0 || q1.size() != 0) && n < 3000) begin
      tick; n++;
    end
    checks++; if (n >= 3000) fail("drain_timeout");
    repeat (5) tick;
  endtask

  initial begin
    logic [7:0] pat;
    rst = 1'b1; valid_a = 1'b0; valid_b = 1'b0; data_a = '0; data_b = '0;
    repeat (2) tick;
    checks++; if (tx_a !== 1'b1) fail("rst_tx");
    checks++; if (ready_a !== 1'b1) fail("rst_ready");
    checks++; if (busy_a !== 1'b0) fail("rst_busy");
    checks++; if (count_a !== 3'd0) fail("rst_count");
    rst = 1'b0;

    for (int c = 0; c < 100; c++) begin
      tick;
      checks++; if (tx_a !== 1'b1) fail("idle_tx");
      checks++; if (ready_a !== 1'b1) fail("idle_ready");
      checks++; if (busy_a !== 1'b0) fail("idle_busy");
      checks++; if (count_a !== 3'd0) fail("idle_count");
      checks++; if (tx_b !== 1'b1) fail("idle_tx_b");
    end

    // Single byte 0x55, cycle-exact line shape.
    pat = 8'h55;
    push_a(pat, 1'b1);
    checks++; if (count_a !== 3'd1) fail("push_count");
    checks++; if (tx_a !== 1'b1) fail("push_tx_still_idle");
    tick;
    checks++; if (tx_a !== 1'b0) fail("pop_start_low");
    checks++; if (count_a !== 3'd0) fail("pop_count");
    checks++; if (busy_a !== 1'b1) fail("pop_busy");
    repeat (3) begin
      tick;
      checks++; if (tx_a !== 1'b0) fail("start_bit");
    end
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < CPB_A; j++) begin
        tick;
        checks++; if (tx_a !== pat[i]) fail("data_bit_55");
      end
    end
    for (int j = 0; j < CPB_A; j++) begin
      tick;
      checks++; if (tx_a !== 1'b1) fail("stop_bit");
      checks++; if (busy_a !== 1'b1) fail("stop_busy");
    end
    tick;
    checks++; if (busy_a !== 1'b0) fail("busy_fall");
    checks++; if (tx_a !== 1'b1) fail("idle_after_frame");
    drain;

    // Burst with valid held: FIFO fills, frames run back-to-back.
    st0.delete();
    for (int b = 0; b < 5; b++) push_a(8'h41 + 8'(b), 1'b1);
    checks++; if (ready_a !== 1'b0) fail("burst_full_ready");
    checks++; if (count_a !== 3'd4) fail("burst_full_count");
    drain;
    checks++; if (st0.size() != 5) fail("burst_frames");
    for (int f = 1; f < st0.size(); f++) begin
      checks++; if ((st0[f] - st0[f-1]) != 10 * CPB_A) fail("burst_gap");
    end

    // Push on the same edge as the stop-bit pop, with two bytes queued.
    push_a(8'h11, 1'b1);
    push_a(8'h22, 1'b1);
    push_a(8'h33, 1'b1);
    repeat (38) tick;
    checks++; if (count_a !== 3'd2) fail("simul_pre_count");
    checks++; if (tx_a !== 1'b1) fail("simul_pre_stop");
    push_a(8'h44, 1'b1);
    checks++; if (count_a !== 3'd2) fail("simul_post_count");
    checks++; if (tx_a !== 1'b0) fail("simul_post_start");
    drain;

    // Reset in the middle of a data bit with two bytes queued.
    push_a(8'hA5, 1'b0);
    push_a(8'h01, 1'b0);
    push_a(8'h02, 1'b0);
    checks++; if (count_a !== 3'd2) fail("midrst_queued");
    repeat (12) tick;
    rst = 1'b1;
    tick;
    checks++; if (tx_a !== 1'b1) fail("midrst_tx");
    checks++; if (count_a !== 3'd0) fail("midrst_count");
    checks++; if (busy_a !== 1'b0) fail("midrst_busy");
    checks++; if (ready_a !== 1'b1) fail("midrst_ready");
    rst = 1'b0;
    for (int c = 0; c < 100; c++) begin
      tick;
      checks++; if (tx_a !== 1'b1) fail("post_rst_quiet");
    end
    checks++; if (busy_a !== 1'b0) fail("post_rst_busy");

    // Minimum configuration: 2 clocks per bit, 2-entry FIFO.
    st1.delete();
    push_b(8'hFF);
    checks++; if (count_b !== 2'd1) fail("b_count_1");
    push_b(8'h00);
    checks++; if (count_b !== 2'd1) fail("b_count_simul");
    drain;
    checks++; if (st1.size() != 2) fail("b_frames");
    if (st1.size() == 2) begin
      checks++; if ((st1[1] - st1[0]) != 10 * CPB_B) fail("b_gap");
    end

    checks++; if (q0.size() != 0) fail("q0_empty");
    checks++; if (q1.size() != 0) fail("q1_empty");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
